// File: rtl/char_buf_ctrl.sv
// Register-mapped text cursor and clear-screen engine sharing one character buffer write port.
//   state | meaning
//   IDLE  | bus DATA writes go straight to the buffer at the cursor
//   CLEAR | one fill write per cycle over every cell; DATA writes are held or dropped
//   DRAIN | one cycle that writes the held character at (0,0)
module char_buf_ctrl #(
    parameter int AW   = 8,
    parameter int DW   = 16,
    parameter int COLS = 160,
    parameter int ROWS = 64
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          do_write,
    input  logic [AW-1:0] w_adr,
    input  logic [DW-1:0] w_data,
    input  logic [AW-1:0] r_adr,
    output logic [DW-1:0] read_data,
    output logic          buf_we,
    output logic [6:0]    buf_row,
    output logic [7:0]    buf_col,
    output logic [7:0]    buf_data,
    output logic          busy
);
    localparam logic [7:0] COL_LAST = 8'(COLS - 1);
    localparam logic [6:0] ROW_LAST = 7'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;

    state_t     state;
    logic [7:0] col, fcol, fill, pend_data;
    logic [6:0] row, frow;
    logic       ovf, pend;

    logic       wr_data, wr_col, wr_row, wr_ctrl, wr_fill, start;
    logic [7:0] col_in, col_adv;
    logic [6:0] row_in, row_adv;

    assign wr_data = do_write && (w_adr == AW'(0));
    assign wr_col  = do_write && (w_adr == AW'(1));
    assign wr_row  = do_write && (w_adr == AW'(2));
    assign wr_ctrl = do_write && (w_adr == AW'(3));
    assign wr_fill = do_write && (w_adr == AW'(4));
    assign start   = wr_ctrl && w_data[0];

    assign col_in = (w_data >= DW'(COLS)) ? COL_LAST : w_data[7:0];
    assign row_in = (w_data >= DW'(ROWS)) ? ROW_LAST : w_data[6:0];

    // Cursor advance: wrap column into next row, wrap last row back to the top.
    always_comb begin
        col_adv = col + 8'd1;
        row_adv = row;
        if (col == COL_LAST) begin
            col_adv = 8'd0;
            row_adv = (row == ROW_LAST) ? 7'd0 : row + 7'd1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            col       <= 8'd0;
            row       <= 7'd0;
            fcol      <= 8'd0;
            frow      <= 7'd0;
            fill      <= 8'h20;
            pend_data <= 8'd0;
            pend      <= 1'b0;
            ovf       <= 1'b0;
            buf_we    <= 1'b0;
            buf_row   <= 7'd0;
            buf_col   <= 8'd0;
            buf_data  <= 8'd0;
        end else begin
            buf_we <= 1'b0;
            if (wr_fill) fill <= w_data[7:0];
            if (wr_ctrl && w_data[1]) ovf <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_col) col <= col_in;
                    if (wr_row) row <= row_in;
                    if (wr_data) begin
                        buf_we   <= 1'b1;
                        buf_row  <= row;
                        buf_col  <= col;
                        buf_data <= w_data[7:0];
                        col      <= col_adv;
                        row      <= row_adv;
                    end
                    if (start) begin
                        state <= CLEAR;
                        frow  <= 7'd0;
                        fcol  <= 8'd0;
                    end
                end
                CLEAR: begin
                    buf_we   <= 1'b1;
                    buf_row  <= frow;
                    buf_col  <= fcol;
                    buf_data <= fill;
                    if (wr_col) col <= col_in;
                    if (wr_row) row <= row_in;
                    if (wr_data) begin
                        if (pend) begin
                            ovf <= 1'b1;
                        end else begin
                            pend      <= 1'b1;
                            pend_data <= w_data[7:0];
                        end
                    end
                    if (start) begin
                        frow <= 7'd0;
                        fcol <= 8'd0;
                    end else if (fcol == COL_LAST) begin
                        fcol <= 8'd0;
                        if (frow == ROW_LAST) begin
                            // A DATA write landing on the last cell must still drain.
                            frow  <= 7'd0;
                            col   <= 8'd0;
                            row   <= 7'd0;
                            state <= (pend || wr_data) ? DRAIN : IDLE;
                        end else begin
                            frow <= frow + 7'd1;
                        end
                    end else begin
                        fcol <= fcol + 8'd1;
                    end
                end
                DRAIN: begin
                    buf_we   <= 1'b1;
                    buf_row  <= row;
                    buf_col  <= col;
                    buf_data <= pend_data;
                    col      <= col_adv;
                    row      <= row_adv;
                    pend     <= 1'b0;
                    state    <= IDLE;
                    if (wr_col) col <= col_in;
                    if (wr_row) row <= row_in;
                    if (wr_data) begin
                        pend      <= 1'b1;
                        pend_data <= w_data[7:0];
                        state     <= DRAIN;
                    end
                    if (start) begin
                        state <= CLEAR;
                        frow  <= 7'd0;
                        fcol  <= 8'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        read_data = '0;
        case (r_adr)
            AW'(0):  read_data = DW'({ovf, busy});
            AW'(1):  read_data = DW'(col);
            AW'(2):  read_data = DW'(row);
            AW'(4):  read_data = DW'(fill);
            default: read_data = '0;
        endcase
    end
endmodule

// File: tb/tb_char_buf_ctrl.sv
// Self-checking bench for char_buf_ctrl: directed scenarios plus randomized bus traffic
// checked against a linear-cursor reference model.
module tb_char_buf_ctrl;
    localparam int COLS  = 160;
    localparam int ROWS  = 64;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        do_write = 1'b0;
    logic [7:0]  w_adr = '0;
    logic [15:0] w_data = '0;
    logic [7:0]  r_adr = '0;
    logic [15:0] read_data;
    logic        buf_we;
    logic [6:0]  buf_row;
    logic [7:0]  buf_col;
    logic [7:0]  buf_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    char_buf_ctrl #(.AW(8), .DW(16), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .nrst(nrst), .do_write(do_write), .w_adr(w_adr), .w_data(w_data),
        .r_adr(r_adr), .read_data(read_data), .buf_we(buf_we), .buf_row(buf_row),
        .buf_col(buf_col), .buf_data(buf_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] adr, input logic [15:0] data);
        do_write = 1'b1;
        w_adr    = adr;
        w_data   = data;
        @(posedge clk);
        #1;
        do_write = 1'b0;
        w_adr    = '0;
        w_data   = '0;
    endtask

    task automatic read_reg(input logic [7:0] adr, output logic [15:0] val);
        r_adr = adr;
        #1;
        val = read_data;
    endtask

    task automatic test_reset();
        logic [15:0] st, c, r, f;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (buf_we !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_init we=%0b busy=%0b exp 0/0", buf_we, busy);
        end
        @(negedge clk) nrst = 1'b1;
        step();
        bus_write(8'd4, 16'h2E);
        bus_write(8'd1, 16'd10);
        bus_write(8'd3, 16'd1);
        repeat (20) step();
        #2 nrst = 1'b0;
        #1;
        read_reg(8'd0, st);
        read_reg(8'd1, c);
        read_reg(8'd2, r);
        read_reg(8'd4, f);
        checks++;
        if (buf_we !== 1'b0 || st !== 16'h0 || c !== 16'h0 || r !== 16'h0 || f !== 16'h20) begin
            errors++;
            $display("FAIL reset_midrun we=%0b status=%h col=%0d row=%0d fill=%h exp 0/0/0/0/20",
                     buf_we, st, c, r, f);
        end
        @(negedge clk) nrst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] c;
        bus_write(8'd1, 16'd5);
        bus_write(8'd2, 16'd3);
        bus_write(8'd0, 16'h41);
        checks++;
        if (buf_we !== 1'b1 || buf_row !== 7'd3 || buf_col !== 8'd5 || buf_data !== 8'h41) begin
            errors++;
            $display("FAIL basic_write we=%0b row=%0d col=%0d data=%h exp 1/3/5/41",
                     buf_we, buf_row, buf_col, buf_data);
        end
        read_reg(8'd1, c);
        checks++;
        if (c !== 16'd6) begin errors++; $display("FAIL basic_col got=%0d exp=6", c); end
        step();
        checks++;
        if (buf_we !== 1'b0) begin errors++; $display("FAIL basic_single_pulse we=%0b exp=0", buf_we); end
    endtask

    task automatic test_wrap();
        logic [15:0] c, r;
        bus_write(8'd1, 16'(COLS - 1));
        bus_write(8'd2, 16'(ROWS - 1));
        bus_write(8'd0, 16'h42);
        checks++;
        if (buf_we !== 1'b1 || buf_row !== 7'(ROWS - 1) || buf_col !== 8'(COLS - 1) || buf_data !== 8'h42) begin
            errors++;
            $display("FAIL wrap_write we=%0b row=%0d col=%0d data=%h exp 1/63/159/42",
                     buf_we, buf_row, buf_col, buf_data);
        end
        read_reg(8'd1, c);
        read_reg(8'd2, r);
        checks++;
        if (c !== 16'd0 || r !== 16'd0) begin
            errors++; $display("FAIL wrap_cursor col=%0d row=%0d exp 0/0", c, r);
        end
    endtask

    task automatic test_clamp();
        logic [15:0] c, r;
        bus_write(8'd1, 16'd300);
        bus_write(8'd2, 16'd200);
        read_reg(8'd1, c);
        read_reg(8'd2, r);
        checks++;
        if (c !== 16'd159 || r !== 16'd63) begin
            errors++; $display("FAIL clamp_big col=%0d row=%0d exp 159/63", c, r);
        end
        bus_write(8'd1, 16'(COLS));
        bus_write(8'd2, 16'(ROWS - 2));
        read_reg(8'd1, c);
        read_reg(8'd2, r);
        checks++;
        if (c !== 16'(COLS - 1) || r !== 16'(ROWS - 2)) begin
            errors++; $display("FAIL clamp_edge col=%0d row=%0d exp 159/62", c, r);
        end
    endtask

    // Model keeps the cursor as a linear cell index; row/col are derived by division.
    task automatic test_random();
        int m_pos, m_fill, v, exp_r, exp_c;
        logic [7:0]  ch;
        logic [15:0] c, r, f, st;
        bus_write(8'd1, 16'd0);
        bus_write(8'd2, 16'd0);
        bus_write(8'd4, 16'h20);
        m_pos  = 0;
        m_fill = 'h20;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 4))
                0: begin
                    ch    = 8'($urandom);
                    exp_r = m_pos / COLS;
                    exp_c = m_pos % COLS;
                    bus_write(8'd0, {8'h00, ch});
                    checks++;
                    if (buf_we !== 1'b1 || buf_row !== 7'(exp_r) || buf_col !== 8'(exp_c) || buf_data !== ch) begin
                        errors++;
                        $display("FAIL rand_data we=%0b row=%0d col=%0d data=%h exp 1/%0d/%0d/%h",
                                 buf_we, buf_row, buf_col, buf_data, exp_r, exp_c, ch);
                    end
                    m_pos = (m_pos + 1) % CELLS;
                end
                1: begin
                    v = $urandom_range(0, 400);
                    bus_write(8'd1, 16'(v));
                    if (v > COLS - 1) v = COLS - 1;
                    m_pos = (m_pos / COLS) * COLS + v;
                end
                2: begin
                    v = $urandom_range(0, 200);
                    bus_write(8'd2, 16'(v));
                    if (v > ROWS - 1) v = ROWS - 1;
                    m_pos = v * COLS + (m_pos % COLS);
                end
                3: begin
                    v = $urandom_range(0, 255);
                    bus_write(8'd4, 16'(v));
                    m_fill = v;
                end
                default: begin
                    step();
                    checks++;
                    if (buf_we !== 1'b0) begin errors++; $display("FAIL rand_idle we=%0b exp=0", buf_we); end
                end
            endcase
            read_reg(8'd1, c);
            read_reg(8'd2, r);
            read_reg(8'd4, f);
            read_reg(8'd0, st);
            checks++;
            if (c !== 16'(m_pos % COLS) || r !== 16'(m_pos / COLS) || f !== 16'(m_fill) || st !== 16'h0) begin
                errors++;
                $display("FAIL rand_regs col=%0d row=%0d fill=%h st=%h exp %0d/%0d/%h/0",
                         c, r, f, st, m_pos % COLS, m_pos / COLS, m_fill);
            end
        end
    endtask

    task automatic test_clear();
        int bad;
        logic [15:0] c, r;
        bus_write(8'd4, 16'h2E);
        bus_write(8'd1, 16'd7);
        bus_write(8'd2, 16'd9);
        bus_write(8'd3, 16'd1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy_start busy=%0b exp=1", busy); end
        bad = 0;
        for (int k = 0; k < CELLS; k++) begin
            step();
            if (buf_we !== 1'b1 || buf_row !== 7'(k / COLS) || buf_col !== 8'(k % COLS) ||
                buf_data !== 8'h2E || busy !== (k < CELLS - 1)) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL clear_scan bad_cycles=%0d exp=0", bad); end
        read_reg(8'd1, c);
        read_reg(8'd2, r);
        checks++;
        if (busy !== 1'b0 || c !== 16'd0 || r !== 16'd0) begin
            errors++; $display("FAIL clear_end busy=%0b col=%0d row=%0d exp 0/0/0", busy, c, r);
        end
        step();
        checks++;
        if (buf_we !== 1'b0) begin errors++; $display("FAIL clear_after we=%0b exp=0", buf_we); end
    endtask

    task automatic test_drain();
        int  cnt;
        bit  saw59;
        logic [15:0] st, c;
        bus_write(8'd3, 16'd1);
        repeat (5) step();
        bus_write(8'd0, 16'h58);
        bus_write(8'd0, 16'h59);
        read_reg(8'd0, st);
        checks++;
        if (st !== 16'h3) begin errors++; $display("FAIL drain_status_mid got=%h exp=3", st); end
        cnt   = 0;
        saw59 = 1'b0;
        while (busy === 1'b1 && cnt < CELLS + 10) begin
            step();
            cnt++;
            if (buf_we === 1'b1 && buf_data === 8'h59) saw59 = 1'b1;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drain_timeout busy=%0b exp=0", busy); end
        checks++;
        if (buf_we !== 1'b1 || buf_row !== 7'd0 || buf_col !== 8'd0 || buf_data !== 8'h58 || saw59) begin
            errors++;
            $display("FAIL drain_write we=%0b row=%0d col=%0d data=%h saw59=%0b exp 1/0/0/58/0",
                     buf_we, buf_row, buf_col, buf_data, saw59);
        end
        read_reg(8'd0, st);
        read_reg(8'd1, c);
        checks++;
        if (st !== 16'h2 || c !== 16'd1) begin
            errors++; $display("FAIL drain_after status=%h col=%0d exp 2/1", st, c);
        end
        bus_write(8'd3, 16'd2);
        read_reg(8'd0, st);
        checks++;
        if (st !== 16'h0) begin errors++; $display("FAIL ovf_clear status=%h exp=0", st); end
    endtask

    task automatic test_restart();
        int cnt;
        bus_write(8'd3, 16'd1);
        repeat (100) step();
        bus_write(8'd4, 16'h23);
        step();
        checks++;
        if (buf_we !== 1'b1 || buf_data !== 8'h23) begin
            errors++; $display("FAIL fill_midclear we=%0b data=%h exp 1/23", buf_we, buf_data);
        end
        bus_write(8'd3, 16'd1);
        step();
        checks++;
        if (buf_we !== 1'b1 || buf_row !== 7'd0 || buf_col !== 8'd0) begin
            errors++; $display("FAIL restart_origin we=%0b row=%0d col=%0d exp 1/0/0", buf_we, buf_row, buf_col);
        end
        cnt = 1;
        while (busy === 1'b1 && cnt < CELLS + 10) begin
            step();
            cnt++;
        end
        checks++;
        if (cnt != CELLS || busy !== 1'b0) begin
            errors++; $display("FAIL restart_length cycles=%0d busy=%0b exp %0d/0", cnt, busy, CELLS);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_clamp();
        test_random();
        test_clear();
        test_drain();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
